// File: rtl/seq_counter_ctrl.sv
// Command sequencer for the 0,1,2,3,8,9,10 up/down sequence counter.
// Define SEQ_CTRL_VERIFY_EN to also flag a counter that ends on the wrong value.
module seq_counter_ctrl #(
  parameter int MAX_STEP = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  input  logic [3:0] cnt_value,
  output logic       cnt_load,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic [3:0] cnt_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_CHECK} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [3:0] MAX_N   = 4'(MAX_STEP);

  function automatic logic on_seq(input logic [3:0] v);
    return (v <= 4'd3) || ((v >= 4'd8) && (v <= 4'd10));
  endfunction

  function automatic logic [2:0] to_idx(input logic [3:0] v);
    return v[3] ? 3'(v - 4'd4) : v[2:0];
  endfunction

  function automatic logic [2:0] mod7(input logic [4:0] x);
    return 3'(x % 5'd7);
  endfunction

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic       up_q, up_d;
  logic       arg_err_q, arg_err_d;
  logic       cnt_load_q, cnt_load_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_up_q, cnt_up_d;
  logic [3:0] cnt_data_q, cnt_data_d;
  logic       done_q, done_d;

  logic       cur_ok, arg_ok;
  logic [2:0] cur_idx, arg_idx, seek_d;
  logic [3:0] step_n, n_cmd;
  logic       up_cmd;
  logic       mismatch;

  always_comb begin
    cur_ok  = on_seq(cnt_value);
    arg_ok  = on_seq(cmd_arg);
    cur_idx = to_idx(cnt_value);
    arg_idx = to_idx(cmd_arg);
    step_n  = (cmd_arg > MAX_N) ? MAX_N : cmd_arg;
    seek_d  = mod7(5'd7 + {2'b00, arg_idx} - {2'b00, cur_idx});
  end

`ifdef SEQ_CTRL_VERIFY_EN
  logic [3:0] exp_q, exp_d;
  logic [3:0] step_exp;
  logic [2:0] base_idx;
  logic [3:0] eff_n;

  function automatic logic [3:0] to_val(input logic [2:0] i);
    return (i >= 3'd4) ? ({1'b0, i} + 4'd4) : {1'b0, i};
  endfunction

  // An off-sequence counter snaps to 0 on its first step, then counts normally.
  always_comb begin
    base_idx = cur_ok ? cur_idx : 3'd0;
    eff_n    = cur_ok ? step_n : (step_n - 4'd1);
    step_exp = cnt_value;
    if (step_n != 4'd0) begin
      if (cmd_op == OP_UP)
        step_exp = to_val(mod7({2'b00, base_idx} + {1'b0, eff_n}));
      else
        step_exp = to_val(mod7(5'd21 + {2'b00, base_idx} - {1'b0, eff_n}));
    end
  end

  assign mismatch = (cnt_value != exp_q);
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    up_d       = up_q;
    arg_err_d  = arg_err_q;
    cnt_load_d = 1'b0;
    cnt_en_d   = 1'b0;
    cnt_up_d   = 1'b0;
    cnt_data_d = 4'd0;
    done_d     = 1'b0;
    n_cmd      = 4'd0;
    up_cmd     = 1'b0;
`ifdef SEQ_CTRL_VERIFY_EN
    exp_d      = exp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              state_d    = S_LOAD;
              cnt_load_d = 1'b1;
              cnt_data_d = cmd_arg;
              arg_err_d  = !arg_ok;
`ifdef SEQ_CTRL_VERIFY_EN
              exp_d      = arg_ok ? cmd_arg : 4'd0;
`endif
            end
            OP_UP, OP_DOWN: begin
              up_cmd    = (cmd_op == OP_UP);
              n_cmd     = step_n;
              arg_err_d = (cmd_arg > MAX_N);
`ifdef SEQ_CTRL_VERIFY_EN
              exp_d     = step_exp;
`endif
            end
            default: begin
              // Seek takes the shorter way round the 7-entry ring.
              if (arg_ok && cur_ok) begin
                up_cmd    = (seek_d <= 3'd3);
                n_cmd     = up_cmd ? {1'b0, seek_d} : (4'd7 - {1'b0, seek_d});
                arg_err_d = 1'b0;
`ifdef SEQ_CTRL_VERIFY_EN
                exp_d     = cmd_arg;
`endif
              end else begin
                arg_err_d = 1'b1;
`ifdef SEQ_CTRL_VERIFY_EN
                exp_d     = cnt_value;
`endif
              end
            end
          endcase
          if (cmd_op != OP_LOAD) begin
            up_d  = up_cmd;
            rem_d = n_cmd;
            if (n_cmd == 4'd0) begin
              state_d = S_CHECK;
              done_d  = 1'b1;
            end else begin
              state_d  = S_STEP;
              cnt_en_d = 1'b1;
              cnt_up_d = up_cmd;
            end
          end
        end
      end
      S_LOAD: begin
        state_d = S_CHECK;
        done_d  = 1'b1;
      end
      S_STEP: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d = S_CHECK;
          done_d  = 1'b1;
        end else begin
          cnt_en_d = 1'b1;
          cnt_up_d = up_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_q      <= 4'd0;
      up_q       <= 1'b0;
      arg_err_q  <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_up_q   <= 1'b0;
      cnt_data_q <= 4'd0;
      done_q     <= 1'b0;
`ifdef SEQ_CTRL_VERIFY_EN
      exp_q      <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      up_q       <= up_d;
      arg_err_q  <= arg_err_d;
      cnt_load_q <= cnt_load_d;
      cnt_en_q   <= cnt_en_d;
      cnt_up_q   <= cnt_up_d;
      cnt_data_q <= cnt_data_d;
      done_q     <= done_d;
`ifdef SEQ_CTRL_VERIFY_EN
      exp_q      <= exp_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cnt_load  = cnt_load_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_up    = cnt_up_q;
  assign cnt_data  = cnt_data_q;
  assign done      = done_q;
  // The counter result is only known once CHECK is reached, so err looks at it live.
  assign err       = done_q & (arg_err_q | mismatch);

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Bench for seq_counter_ctrl: a behavioural sequence counter closes the loop and a
// command-level model predicts step count, direction, latency, final value and err.
module tb_seq_counter_ctrl;
  localparam int MAX_STEP = 14;
`ifdef SEQ_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic       cmd_ready, cnt_load, cnt_en, cnt_up, busy, done, err;
  logic [3:0] cnt_data, cnt_value;

  logic [3:0] cnt_q = 4'd0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_val = 4'd0;
  logic       poke_req = 1'b0;
  logic [3:0] poke_val = 4'd0;

  int tests = 0;
  int fails = 0;
  int seq_tab[7] = '{0, 1, 2, 3, 8, 9, 10};

  seq_counter_ctrl #(.MAX_STEP(MAX_STEP)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_value(cnt_value),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_data(cnt_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int mod7(input int x);
    return ((x % 7) + 7) % 7;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 7; i++) if (seq_tab[i] == int'(v)) return i;
    return -1;
  endfunction

  // Sequence counter the controller drives; off-sequence values snap to 0 on a step.
  assign cnt_value = ovr_en ? ovr_val : cnt_q;
  always @(posedge clk) begin
    if (poke_req) cnt_q <= poke_val;
    else if (cnt_load) cnt_q <= (idx_of(cnt_data) < 0) ? 4'd0 : cnt_data;
    else if (cnt_en) begin
      if (idx_of(cnt_q) < 0) cnt_q <= 4'd0;
      else cnt_q <= 4'(seq_tab[mod7(idx_of(cnt_q) + (cnt_up ? 1 : -1))]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [3:0] arg, input logic [3:0] start,
                       output int n, output bit up, output int lat, output bit e,
                       output logic [3:0] fin);
    int ci, ti, d;
    ci = idx_of(start); ti = idx_of(arg);
    n = 0; up = 1'b0; e = 1'b0; fin = start;
    case (op)
      2'd0: begin e = (ti < 0); fin = e ? 4'd0 : arg; end
      2'd1, 2'd2: begin
        up = (op == 2'd1);
        e  = (int'(arg) > MAX_STEP);
        n  = e ? MAX_STEP : int'(arg);
        if (n > 0)
          fin = (ci < 0) ? 4'(seq_tab[mod7(up ? n - 1 : 1 - n)])
                         : 4'(seq_tab[mod7(up ? ci + n : ci - n)]);
      end
      default: begin
        if (ci < 0 || ti < 0) e = 1'b1;
        else begin
          d = mod7(ti - ci);
          up = (d <= 3);
          n = up ? d : 7 - d;
          fin = arg;
        end
      end
    endcase
    lat = (op == 2'd0) ? 2 : n + 1;
  endtask

  task automatic poke(input logic [3:0] v);
    @(negedge clk);
    poke_val = v; poke_req = 1'b1;
    @(posedge clk); #1;
    poke_req = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg, input bit force_wrong,
                         input bit hold, input logic [1:0] nop, input logic [3:0] narg);
    int n, lat, w, cyc, en_c, ld_c, bad;
    bit up, e, got;
    logic [3:0] fin, start;
    w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    check("ready_before_cmd", cmd_ready, 1);
    start = cnt_value;
    model(op, arg, start, n, up, lat, e, fin);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    if (hold) begin cmd_op = nop; cmd_arg = narg; end
    else begin cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = 4'($urandom); end
    cyc = 1; got = 1'b0; en_c = 0; ld_c = 0; bad = 0;
    while (!got && cyc <= 30) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (done === 1'b1) begin
        got = 1'b1;
        if (cnt_en !== 1'b0 || cnt_load !== 1'b0) bad++;
      end else begin
        if (cnt_en === 1'b1) begin en_c++; if (cnt_up !== up) bad++; end
        if (cnt_load === 1'b1) begin ld_c++; if (cnt_data !== arg) bad++; end
        @(posedge clk); #1; cyc++;
      end
    end
    check("done_seen", got, 1);
    if (got) begin
      check("latency", cyc, lat);
      check("steps", en_c, n);
      check("loads", ld_c, (op == 2'd0) ? 1 : 0);
      check("strobe_bad", bad, 0);
      check("final_value", cnt_value, fin);
      if (force_wrong) begin ovr_val = fin ^ 4'h1; ovr_en = 1'b1; #1; end
      check("err", err, e | (force_wrong & VERIFY));
      ovr_en = 1'b0;
      @(posedge clk); #1;
      check("ready_after_done", cmd_ready, 1);
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, lat, bad;
    bit up, e;
    logic [3:0] fin, cs;

    @(posedge clk); @(posedge clk); #1;
    check("rst_cnt_load", cnt_load, 0);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_up", cnt_up, 0);
    check("rst_cnt_data", cnt_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", cmd_ready, 1);
    @(negedge clk); reset = 1'b0;

    run_cmd(2'd0, 4'd9, 0, 0, 0, 0);
    run_cmd(2'd0, 4'd3, 0, 0, 0, 0);
    run_cmd(2'd1, 4'd2, 0, 0, 0, 0);
    run_cmd(2'd0, 4'd0, 0, 0, 0, 0);
    run_cmd(2'd3, 4'd10, 0, 0, 0, 0);
    run_cmd(2'd3, 4'd3, 0, 0, 0, 0);
    run_cmd(2'd0, 4'd5, 0, 0, 0, 0);
    run_cmd(2'd3, 4'd7, 0, 0, 0, 0);
    run_cmd(2'd1, 4'd15, 0, 0, 0, 0);
    run_cmd(2'd2, 4'd14, 0, 0, 0, 0);
    run_cmd(2'd2, 4'd0, 0, 0, 0, 0);
    run_cmd(2'd3, 4'd2, 0, 0, 0, 0);

    // cmd_valid held through a command with a different command already on the bus
    run_cmd(2'd1, 4'd3, 0, 1, 2'd0, 4'd2);
    run_cmd(2'd0, 4'd2, 0, 0, 0, 0);

    poke(4'd5);  run_cmd(2'd1, 4'd3, 0, 0, 0, 0);
    poke(4'd12); run_cmd(2'd2, 4'd2, 0, 0, 0, 0);
    poke(4'd4);  run_cmd(2'd3, 4'd2, 0, 0, 0, 0);
    poke(4'd6);  run_cmd(2'd1, 4'd0, 0, 0, 0, 0);

    run_cmd(2'd0, 4'd2, 1, 0, 0, 0);
    run_cmd(2'd1, 4'd4, 1, 0, 0, 0);

    // reset in the middle of a 5-step command
    @(negedge clk);
    cs = cnt_value;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 4'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_en_first", cnt_en, 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; #1;
    check("mid_rst_en", cnt_en, 0);
    check("mid_rst_up", cnt_up, 0);
    check("mid_rst_load", cnt_load, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", cmd_ready, 1);
    model(2'd1, 4'd2, cs, n, up, lat, e, fin);
    @(negedge clk); reset = 1'b0;
    check("mid_rst_value", cnt_value, fin);
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || cnt_en !== 1'b0) bad++;
    end
    check("mid_rst_quiet", bad, 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) poke(4'($urandom));
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
